// File: rtl/vm1_bus_pkg.sv
// rtl/vm1_bus_pkg.sv - shared bus-arbitration types and constants for the VM1 bus unit
package vm1_bus_pkg;

  typedef enum logic [1:0] {
    S_CPU     = 2'd0,
    S_OFFER   = 2'd1,
    S_DMA     = 2'd2,
    S_RELEASE = 2'd3
  } bus_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RPLY  = 2'd1;
  localparam logic [1:0] ERR_OFFER = 2'd2;

  localparam int RPLY_TIMEOUT_DEF  = 63;
  localparam int OFFER_TIMEOUT_DEF = 15;
  localparam int BUS_CNT_W_DEF     = 6;

endpackage

// File: rtl/vm1_bus_timer.sv
// rtl/vm1_bus_timer.sv - saturating ce-qualified tick counter with single-shot limit hit
module vm1_bus_timer #(
  parameter int CNT_W = 6,
  parameter int LIMIT = 63
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic clear,
  input  logic run,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (ce) begin
      if (clear) begin
        cnt <= '0;
      end else if (run && cnt != MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Fires only on the tick that brings the count to LIMIT; saturation keeps it from re-firing.
  assign hit = ce && run && !clear && (cnt == LAST);

endmodule

// File: rtl/qbus_arbiter.sv
// rtl/qbus_arbiter.sv - CPU/DMA bus-mastership arbiter with reply and offer timeouts
module qbus_arbiter
  import vm1_bus_pkg::*;
#(
  parameter int RPLY_TIMEOUT  = RPLY_TIMEOUT_DEF,
  parameter int OFFER_TIMEOUT = OFFER_TIMEOUT_DEF,
  parameter int CNT_W         = BUS_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       cpu_req_i,
  input  logic       cpu_sync_i,
  input  logic       rply_i,
  input  logic       dmr_i,
  input  logic       sack_i,
  output logic       dmgo_o,
  output logic       cpu_hold_o,
  output logic       dma_owner_o,
  output logic       berror_o,
  output logic [1:0] err_code_o
);

  bus_state_t state, next_state;
  logic owed, sync_q;
  logic rply_clear, rply_run, rply_hit;
  logic offer_clear, offer_run, offer_hit, offer_fail;

  assign rply_clear  = !cpu_sync_i || rply_i;
  assign rply_run    = (state == S_CPU) && cpu_sync_i && !rply_i;
  assign offer_clear = (state != S_OFFER);
  assign offer_run   = (state == S_OFFER);

  vm1_bus_timer #(.CNT_W(CNT_W), .LIMIT(RPLY_TIMEOUT)) u_rply_timer (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .clear(rply_clear), .run(rply_run), .hit(rply_hit)
  );

  vm1_bus_timer #(.CNT_W(CNT_W), .LIMIT(OFFER_TIMEOUT)) u_offer_timer (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .clear(offer_clear), .run(offer_run), .hit(offer_hit)
  );

  // SACK beats both a withdrawn request and an expiring offer on the same tick.
  always_comb begin
    next_state = state;
    offer_fail = 1'b0;
    case (state)
      S_CPU:     if (dmr_i && !cpu_sync_i && !owed) next_state = S_OFFER;
      S_OFFER: begin
        if (sack_i) begin
          next_state = S_DMA;
        end else if (!dmr_i) begin
          next_state = S_CPU;
        end else if (offer_hit) begin
          next_state = S_CPU;
          offer_fail = 1'b1;
        end
      end
      S_DMA:     if (!sack_i) next_state = S_RELEASE;
      S_RELEASE: next_state = S_CPU;
      default:   next_state = S_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_CPU;
      owed        <= 1'b0;
      sync_q      <= 1'b0;
      dmgo_o      <= 1'b0;
      cpu_hold_o  <= 1'b0;
      dma_owner_o <= 1'b0;
      berror_o    <= 1'b0;
      err_code_o  <= ERR_NONE;
    end else if (ce) begin
      state       <= next_state;
      sync_q      <= cpu_sync_i;
      dmgo_o      <= (next_state == S_OFFER);
      cpu_hold_o  <= (next_state != S_CPU);
      dma_owner_o <= (next_state == S_DMA);
      berror_o    <= rply_hit || offer_fail;
      if (rply_hit) begin
        err_code_o <= ERR_RPLY;
      end else if (offer_fail) begin
        err_code_o <= ERR_OFFER;
      end
      // The CPU is owed one full cycle after a DMA tenure if it was waiting.
      if (state == S_RELEASE) begin
        owed <= cpu_req_i;
      end else if ((sync_q && !cpu_sync_i) || (state == S_CPU && !cpu_req_i)) begin
        owed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qbus_arbiter.sv
// tb/tb_qbus_arbiter.sv - scoreboard bench for qbus_arbiter against a behavioural model
module tb_qbus_arbiter;

  localparam int RPLY_TO  = 63;
  localparam int OFFER_TO = 15;
  localparam int M_CPU = 0, M_OFFER = 1, M_DMA = 2, M_REL = 3;

  logic clk = 1'b0;
  logic reset_n, ce, cpu_req, cpu_sync, rply, dmr, sack;
  logic dmgo, hold, owner, berror;
  logic [1:0] err_code;

  qbus_arbiter #(.RPLY_TIMEOUT(RPLY_TO), .OFFER_TIMEOUT(OFFER_TO), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .cpu_req_i(cpu_req), .cpu_sync_i(cpu_sync), .rply_i(rply),
    .dmr_i(dmr), .sack_i(sack),
    .dmgo_o(dmgo), .cpu_hold_o(hold), .dma_owner_o(owner),
    .berror_o(berror), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc = 0;
  bit armed = 1'b0;
  string phase = "init";
  logic [5:0] exp_q[$];

  // Reference model: who owns the bus, how long the current wait has lasted.
  int m_st, m_rcnt, m_ocnt;
  bit m_owed, m_psync;
  logic [1:0] m_err;
  logic [5:0] last_exp;

  task automatic model_reset();
    m_st = M_CPU; m_rcnt = 0; m_ocnt = 0;
    m_owed = 1'b0; m_psync = 1'b0; m_err = 2'd0; last_exp = '0;
  endtask

  task automatic model_tick(input logic req, input logic sy, input logic rp,
                            input logic dr, input logic sk);
    int nxt;
    bit berr;
    nxt = m_st;
    berr = 1'b0;
    if (!sy || rp) begin
      m_rcnt = 0;
    end else if (m_st == M_CPU && m_rcnt < RPLY_TO) begin
      m_rcnt++;
      if (m_rcnt == RPLY_TO) begin berr = 1'b1; m_err = 2'd1; end
    end
    case (m_st)
      M_CPU: if (dr && !sy && !m_owed) nxt = M_OFFER;
      M_OFFER: begin
        m_ocnt++;
        if (sk) nxt = M_DMA;
        else if (!dr) nxt = M_CPU;
        else if (m_ocnt == OFFER_TO) begin nxt = M_CPU; berr = 1'b1; m_err = 2'd2; end
      end
      M_DMA: if (!sk) nxt = M_REL;
      default: nxt = M_CPU;
    endcase
    if (m_st == M_REL) m_owed = req;
    else if ((m_psync && !sy) || (m_st == M_CPU && !req)) m_owed = 1'b0;
    m_psync = sy;
    if (nxt != M_OFFER) m_ocnt = 0;
    m_st = nxt;
    last_exp = {nxt == M_OFFER, nxt != M_CPU, nxt == M_DMA, berr, m_err};
  endtask

  task automatic cycle(input logic req, input logic sy, input logic rp,
                       input logic dr, input logic sk, input logic en);
    @(negedge clk);
    cpu_req = req; cpu_sync = sy; rply = rp; dmr = dr; sack = sk; ce = en;
    if (en) model_tick(req, sy, rp, dr, sk);
    exp_q.push_back(last_exp);
    armed = 1'b1;
    cyc++;
  endtask

  task automatic drain();
    @(posedge clk);
    #2;
    armed = 1'b0;
  endtask

  task automatic check_const(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        got_v = {dmgo, hold, owner, berror, err_code};
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL %s cyc=%0d dmgo,hold,own,berr,err got=%b exp=%b", phase, cyc, got_v, exp_v);
        end
        if (berror) pulses++;
      end else if (armed) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow cyc=%0d got=empty exp=entry", cyc);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    int p0;
    logic r_req, r_sync, r_rply, r_dmr, r_sack;
    reset_n = 1'b0; ce = 1'b0;
    cpu_req = 0; cpu_sync = 0; rply = 0; dmr = 0; sack = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_const("reset_outputs", int'({dmgo, hold, owner, berror, err_code}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    phase = "dmr_during_sync";
    cycle(1, 1, 0, 0, 0, 1);
    for (int t = 1; t <= 7; t++) cycle(1, 1, 0, 1, 0, 1);
    for (int t = 8; t <= 10; t++) cycle(1, 0, 0, 1, 0, 1);
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 1);
    repeat (3) cycle(0, 0, 0, 0, 0, 1);

    phase = "idle_grant";
    for (int t = 0; t < 2; t++) cycle(0, 0, 0, 0, 0, 1);
    for (int t = 2; t < 5; t++) cycle(0, 0, 0, 1, 0, 1);
    for (int t = 5; t < 9; t++) cycle(1, 0, 0, 1, 1, 1);
    for (int t = 9; t < 12; t++) cycle(1, 0, 0, 1, 0, 1);

    phase = "owed_cycle";
    for (int t = 0; t < 4; t++) cycle(1, 0, 0, 1, 0, 1);
    for (int t = 0; t < 3; t++) cycle(1, 1, 1, 1, 0, 1);
    for (int t = 0; t < 3; t++) cycle(1, 0, 0, 1, 0, 1);
    cycle(1, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0, 1);

    phase = "reply_timeout";
    p0 = pulses;
    for (int t = 0; t < 70; t++) cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    check_const("rply_single_pulse", pulses - p0, 1);
    check_const("rply_err_code", int'(err_code), 1);
    for (int t = 0; t < 62; t++) cycle(1, 1, 0, 0, 0, 1);
    cycle(1, 1, 1, 0, 0, 1);
    for (int t = 0; t < 70; t++) cycle(1, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_const("rply_restart_pulse", pulses - p0, 2);

    phase = "offer_timeout";
    p0 = pulses;
    for (int t = 0; t < 16; t++) cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    check_const("offer_err_code", int'(err_code), 2);
    check_const("offer_pulse", pulses - p0, 1);
    check_const("offer_dmgo_dropped", int'(dmgo), 0);
    for (int t = 0; t < 5; t++) cycle(0, 0, 0, 1, 0, 1);
    for (int t = 0; t < 3; t++) cycle(0, 0, 0, 0, 0, 1);

    phase = "reset_in_dma";
    cycle(0, 0, 0, 1, 0, 1);
    for (int t = 0; t < 3; t++) cycle(0, 0, 0, 1, 1, 1);
    drain();
    check_const("dma_owner_before_reset", int'(owner), 1);
    #1 reset_n = 1'b0;
    #1;
    check_const("async_reset_outputs", int'({dmgo, hold, owner, berror, err_code}), 0);
    ce = 1'b0; dmr = 0; sack = 0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 1, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);

    phase = "random";
    r_req = 1; r_sync = 0; r_rply = 0; r_dmr = 0; r_sack = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r_sync = ~r_sync;
      r_rply = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) r_dmr = ~r_dmr;
      if ($urandom_range(0, 5) == 0) r_sack = ~r_sack;
      r_req = ($urandom_range(0, 3) != 0);
      cycle(r_req, r_sync, r_rply, r_dmr, r_sack, $urandom_range(0, 4) != 0);
    end
    drain();
    check_const("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
